pcx_pkt_collector: RTL and testbench
====================================

Name: pcx_pkt_collector

Overview:
- Sits directly downstream of the opensparc_t1 PCX port.
- Consumes the 32-bit pcx_data word stream under the pcx_valid/pcx_stall handshake and reassembles fixed-length PCX packets (default 5 words = 160 bits).
- Buffers completed packets in a small packet FIFO and presents them on a ready/valid interface toward the host stream.
- Asserts pcx_stall exactly when no packet slot can accept a completed packet.

Parameters:
- WORDS_PER_PKT, 5: 32-bit words per PCX packet; packet width = 32*WORDS_PER_PKT.
- PKT_DEPTH, 2: completed-packet FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high; one clock, no other clock domains.
- pcx_valid  in  1  pcx_data holds a valid word this cycle.
- pcx_data  in  32  PCX word, most-significant word of the packet first.
- pcx_stall  out  1  registered; while high, upstream words are not accepted.
- pkt_valid  out  1  head packet of the FIFO is available.
- pkt_ready  in  1  consumer accepts the head packet when pkt_valid and pkt_ready are both high.
- pkt_data  out  32*WORDS_PER_PKT  head packet; first received word occupies the top 32 bits.
- pkt_count  out  32  number of packets delivered (popped); wraps 0xFFFFFFFF to 0.
- word_idx  out  $clog2(WORDS_PER_PKT)  index of the next word in the packet under assembly (debug).

Behaviour:
- Reset (asynchronous assert, synchronous to clk on release): FIFO empty, word_idx=0, assembly register=0, pcx_stall=0, pkt_valid=0, pkt_data=0, pkt_count=0.
- Word accept: accept = pcx_valid & ~pcx_stall. Words presented while pcx_stall=1 are ignored; upstream holds them.
- Assembly:
  - On accept, shift the word into the low 32 bits of the assembly register (previous contents shift up) and increment word_idx.
  - When word_idx==WORDS_PER_PKT-1 and accept, the completed packet (register contents plus the current word) is pushed into the FIFO in the same edge, and word_idx wraps to 0.
- Push is guaranteed legal: pcx_stall=1 whenever the FIFO is full, so no word, final or otherwise, is accepted while full. There is no overflow path.
- pcx_stall is registered: pcx_stall <= (count_next == PKT_DEPTH), where count_next = count + push - pop.
  - After a push fills the FIFO, stall is high on the next cycle.
  - After a pop frees a slot, stall drops on the next cycle (one-cycle bubble, accepted).
- Partial packet while stalled: the assembly register and word_idx hold; assembly resumes when stall drops. A stall mid-packet is legal.
- Output:
  - pkt_valid = (count != 0).
  - pkt_data = FIFO head, driven straight from storage with no extra register.
  - Pop = pkt_valid & pkt_ready.
- Simultaneous push and pop: allowed in any state, including full (push cannot occur when full because stall is high) and count==1 with a pop. Count is unchanged and ordering is preserved.
- Latency: a packet becomes pkt_valid the cycle after its final word is accepted.
- pkt_ready while pkt_valid=0: no effect.
- pkt_count: increments on each pop, 32-bit wrap.
- Reset mid-packet or with the FIFO non-empty: all partial and buffered packets are discarded; no pkt_valid after reset until a full new packet arrives.
- FIFO pointers are log2(PKT_DEPTH) bits and wrap naturally. count is log2(PKT_DEPTH)+1 bits.

Decomposition:
- Shared package pcx_pkg:
  - PCX_WORD_W = 32.
  - Default WORDS_PER_PKT.
  - Packet-width localparam.
  - Packet typedef for the 160-bit vector.
- Sub-module pkt_fifo: a generic width/depth synchronous FIFO with push, pop, full, empty and count.
  - Instantiated once. pcx_pkt_collector keeps the assembly and stall logic.

Test Plan:
- Basic: after reset, send words 0x00011904, 0x38008030, 0, 0, 0 on consecutive cycles with pkt_ready=1 -> pkt_valid one cycle after the 5th word; pkt_data = 160'h00011904_38008030_00000000_00000000_00000000; pkt_count=1.
- Backpressure: pkt_ready=0, stream 3 packets back-to-back -> packets 1 and 2 are buffered; pcx_stall rises the cycle after word 10 and holds; words of packet 3 are not accepted (word_idx stays 0). Raise pkt_ready -> all three packets are delivered in order, and pkt_count ends at 3.
- Stall mid-packet: fill the FIFO, then offer 2 words of packet 3 -> none are accepted. Pop one packet -> stall drops one cycle later and packet 3 assembles correctly from its first word.
- Simultaneous push and pop at count==1: the final word arrives in the same cycle as a pop -> count stays 1 and the next pkt_data is the new packet, with no packet lost or duplicated.
- Reset mid-packet: after 3 words, pulse rst asynchronously between edges -> outputs return to reset values immediately. Then send a full packet 0xC0286001, ... -> the delivered packet contains only the post-reset words.
- Gapped input: a valid word every 3rd cycle with random pkt_ready -> packet contents match the input stream, pcx_stall is never high while the FIFO is below PKT_DEPTH, and pkt_count wraps correctly when preloaded near 0xFFFFFFFF (force or run-long variant).

Source files
------------

// File: rtl/pcx_pkg.sv
// Shared PCX word/packet widths and the packet vector type used by the
// collector and its testbench.
package pcx_pkg;

   localparam int PCX_WORD_W        = 32;
   localparam int PCX_WORDS_PER_PKT = 5;
   localparam int PCX_PKT_W         = PCX_WORD_W * PCX_WORDS_PER_PKT;

   typedef logic [PCX_PKT_W-1:0] pcx_pkt_t;

endpackage

// File: rtl/pkt_fifo.sv
// Generic synchronous FIFO; the head entry is driven straight from storage.
// DEPTH must be a power of two so the pointers wrap on their own.
module pkt_fifo #(
   parameter  int WIDTH = 160,
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Out-of-range requests are dropped here so the storage can never corrupt.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/pcx_pkt_collector.sv
// Reassembles fixed-length PCX packets from the 32-bit word stream and queues
// them toward the host on a ready/valid interface.
module pcx_pkt_collector
   import pcx_pkg::*;
#(
   parameter  int WORDS_PER_PKT = PCX_WORDS_PER_PKT,
   parameter  int PKT_DEPTH     = 2,
   localparam int PKT_W         = PCX_WORD_W * WORDS_PER_PKT,
   localparam int IDX_W         = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1,
   localparam int CNT_W         = $clog2(PKT_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pcx_valid,
   input  logic [PCX_WORD_W-1:0] pcx_data,
   output logic                  pcx_stall,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic [PKT_W-1:0]      pkt_data,
   output logic [31:0]           pkt_count,
   output logic [IDX_W-1:0]      word_idx
);

   logic [PKT_W-1:0] asm_q, asm_d, pkt_next;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             stall_q, stall_d;
   logic [31:0]      pkt_count_q, pkt_count_d;
   logic [CNT_W-1:0] fifo_count, count_next;
   logic             fifo_full, fifo_empty;
   logic             accept, last_word, push, pop;

   // fifo_full is redundant with stall_q, kept so a full FIFO can never take a word.
   assign accept    = pcx_valid & ~stall_q & ~fifo_full;
   assign last_word = (idx_q == IDX_W'(WORDS_PER_PKT - 1));
   assign push      = accept & last_word;
   assign pop       = pkt_valid & pkt_ready;
   assign pkt_next  = {asm_q[PKT_W-PCX_WORD_W-1:0], pcx_data};

   always_comb begin
      asm_d       = asm_q;
      idx_d       = idx_q;
      pkt_count_d = pkt_count_q;
      if (accept) begin
         asm_d = pkt_next;
         idx_d = last_word ? '0 : idx_q + 1'b1;
      end
      if (pop) pkt_count_d = pkt_count_q + 32'd1;
   end

   // Stall looks one edge ahead so it is already high when the FIFO becomes full.
   assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign stall_d    = (count_next == CNT_W'(PKT_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_q       <= '0;
         idx_q       <= '0;
         stall_q     <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         asm_q       <= asm_d;
         idx_q       <= idx_d;
         stall_q     <= stall_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   pkt_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (PKT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (pkt_next),
      .pop_i   (pop),
      .data_o  (pkt_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign pkt_valid = ~fifo_empty;
   assign pcx_stall = stall_q;
   assign pkt_count = pkt_count_q;
   assign word_idx  = idx_q;

endmodule

// File: tb/tb_pcx_pkt_collector.sv
// Directed bench for pcx_pkt_collector: reassembly, backpressure, stall
// mid-packet, push/pop overlap, async reset and a gapped stream with wrap.
module tb_pcx_pkt_collector;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pcx_valid = 1'b0;
   logic [31:0]  pcx_data = '0;
   logic         pcx_stall;
   logic         pkt_valid;
   logic         pkt_ready = 1'b0;
   logic [159:0] pkt_data;
   logic [31:0]  pkt_count;
   logic [2:0]   word_idx;

   int checks = 0;
   int errors = 0;

   int           sent, widx, gap, mcnt, guard;
   bit           acc, popm;
   logic [159:0] asm_m;
   logic [159:0] expq[$];

   always #5 clk = ~clk;

   pcx_pkt_collector dut (
      .clk       (clk),
      .rst       (rst),
      .pcx_valid (pcx_valid),
      .pcx_data  (pcx_data),
      .pcx_stall (pcx_stall),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_data  (pkt_data),
      .pkt_count (pkt_count),
      .word_idx  (word_idx)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] w(input int p, input int i);
      return 32'hB000_0000 | (32'(p) << 8) | 32'(i);
   endfunction

   function automatic logic [159:0] mk(input int p);
      return {w(p,0), w(p,1), w(p,2), w(p,3), w(p,4)};
   endfunction

   initial begin
      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 160'(pkt_valid), 160'd0);
      chk("rst_stall", 160'(pcx_stall), 160'd0);
      chk("rst_data",  pkt_data,        160'd0);
      chk("rst_count", 160'(pkt_count), 160'd0);
      chk("rst_idx",   160'(word_idx),  160'd0);
      rst = 1'b0;

      // ---------------- basic ----------------
      pkt_ready = 1'b1;
      pcx_valid = 1'b1;
      pcx_data = 32'h0001_1904; step();
      pcx_data = 32'h3800_8030; step();
      pcx_data = 32'h0;         step();
      chk("basic_idx3", 160'(word_idx), 160'd3);
      chk("basic_novalid", 160'(pkt_valid), 160'd0);
      step();
      step();
      pcx_valid = 1'b0;
      chk("basic_valid", 160'(pkt_valid), 160'd1);
      chk("basic_data", pkt_data, 160'h00011904_38008030_00000000_00000000_00000000);
      step();
      chk("basic_count", 160'(pkt_count), 160'd1);
      chk("basic_drained", 160'(pkt_valid), 160'd0);

      // ---------------- backpressure ----------------
      pkt_ready = 1'b0;
      pcx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pcx_data = w(i / 5, i % 5);
         step();
         if (i == 4) chk("bp_nostall_after_p0", 160'(pcx_stall), 160'd0);
      end
      chk("bp_stall_high", 160'(pcx_stall), 160'd1);
      chk("bp_head_p0", pkt_data, mk(0));
      pcx_data = w(2, 0);
      repeat (3) step();
      chk("bp_idx_held", 160'(word_idx), 160'd0);
      chk("bp_stall_held", 160'(pcx_stall), 160'd1);
      chk("bp_head_still_p0", pkt_data, mk(0));
      // pop one: stall drops one cycle later, then packet 2 assembles
      pkt_ready = 1'b1;
      step();
      pkt_ready = 1'b0;
      chk("bp_stall_dropped", 160'(pcx_stall), 160'd0);
      chk("bp_head_p1", pkt_data, mk(1));
      chk("bp_count2", 160'(pkt_count), 160'd2);
      chk("bp_idx_before_resume", 160'(word_idx), 160'd0);
      step();
      chk("bp_first_word_taken", 160'(word_idx), 160'd1);
      for (int i = 1; i < 5; i++) begin
         pcx_data = w(2, i);
         step();
      end
      pcx_valid = 1'b0;
      chk("bp_refull_stall", 160'(pcx_stall), 160'd1);
      chk("bp_refull_idx", 160'(word_idx), 160'd0);
      pkt_ready = 1'b1;
      step();
      chk("bp_head_p2", pkt_data, mk(2));
      chk("bp_stall_low", 160'(pcx_stall), 160'd0);
      step();
      chk("bp_count4", 160'(pkt_count), 160'd4);
      chk("bp_empty", 160'(pkt_valid), 160'd0);

      // ---------------- simultaneous push/pop at count==1 ----------------
      pkt_ready = 1'b0;
      pcx_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         pcx_data = w(3 + i / 5, i % 5);
         step();
      end
      chk("pp_head_p3", pkt_data, mk(3));
      pcx_data = w(4, 4);
      pkt_ready = 1'b1;
      step();
      pcx_valid = 1'b0;
      chk("pp_valid", 160'(pkt_valid), 160'd1);
      chk("pp_head_p4", pkt_data, mk(4));
      chk("pp_stall", 160'(pcx_stall), 160'd0);
      chk("pp_count5", 160'(pkt_count), 160'd5);
      step();
      chk("pp_count6", 160'(pkt_count), 160'd6);
      chk("pp_empty", 160'(pkt_valid), 160'd0);

      // ---------------- reset mid-packet with FIFO non-empty ----------------
      pkt_ready = 1'b0;
      pcx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pcx_data = w(5 + i / 5, i % 5);
         step();
      end
      pcx_valid = 1'b0;
      chk("rm_idx3", 160'(word_idx), 160'd3);
      chk("rm_valid_before", 160'(pkt_valid), 160'd1);
      #2 rst = 1'b1;
      #1;
      chk("rm_valid", 160'(pkt_valid), 160'd0);
      chk("rm_idx", 160'(word_idx), 160'd0);
      chk("rm_count", 160'(pkt_count), 160'd0);
      chk("rm_data", pkt_data, 160'd0);
      #2 rst = 1'b0;
      step();
      chk("rm_still_empty", 160'(pkt_valid), 160'd0);
      pcx_valid = 1'b1;
      pcx_data = 32'hC028_6001; step();
      pcx_data = 32'h0000_0000; step();
      pcx_data = 32'h1234_5678; step();
      pcx_data = 32'h9ABC_DEF0; step();
      pcx_data = 32'h0000_FFFF; step();
      pcx_valid = 1'b0;
      chk("rm_new_valid", 160'(pkt_valid), 160'd1);
      chk("rm_new_data", pkt_data, 160'hC0286001_00000000_12345678_9ABCDEF0_0000FFFF);
      pkt_ready = 1'b1;
      step();
      chk("rm_new_count", 160'(pkt_count), 160'd1);

      // ---------------- gapped input, random ready, count wrap ----------------
      pkt_ready = 1'b0;
      force dut.pkt_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.pkt_count_q;
      step();
      chk("gap_preload", 160'(pkt_count), 160'hFFFF_FFFE);
      sent = 0; widx = 0; gap = 0; mcnt = 0; asm_m = '0;
      guard = 0;
      while ((sent < 15 || expq.size() != 0) && guard < 3000) begin
         guard++;
         if (sent < 15 && gap == 0) begin
            pcx_valid = 1'b1;
            pcx_data  = 32'h5A00_0000 + 32'(sent);
         end else begin
            pcx_valid = 1'b0;
         end
         pkt_ready = (sent < 15) ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("gap_stall", 160'(pcx_stall), 160'(mcnt == 2));
         chk("gap_valid", 160'(pkt_valid), 160'(mcnt != 0));
         acc  = pcx_valid && (mcnt != 2);
         popm = pkt_valid && pkt_ready;
         if (popm && expq.size() != 0) begin
            chk("gap_data", pkt_data, expq[0]);
            void'(expq.pop_front());
            mcnt--;
         end
         if (acc) begin
            asm_m = {asm_m[127:0], pcx_data};
            sent++;
            widx++;
            gap = 2;
            if (widx == 5) begin
               expq.push_back(asm_m);
               widx = 0;
               mcnt++;
            end
         end else if (!pcx_valid && gap > 0) begin
            gap--;
         end
         step();
      end
      pcx_valid = 1'b0;
      pkt_ready = 1'b0;
      if (guard >= 3000) begin
         errors++;
         $display("FAIL gap_timeout sent=%0d pending=%0d required=all delivered", sent, expq.size());
      end
      chk("gap_wrap_count", 160'(pkt_count), 160'd1);
      chk("gap_final_empty", 160'(pkt_valid), 160'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
